// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the matrix-multiply address sequencer:
// the default index width and the FSM state encoding.
package mac_sequencer_pkg;

    localparam int DIM_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Control/address bundle between the sequencer and its requester/datapath.
// The master side issues start/dim; the slave side (the sequencer) drives
// indices, addresses and the accumulator/write strobes.
interface mac_sequencer_if #(
    parameter int DIM_W = mac_sequencer_pkg::DIM_W
);
    logic                 start;
    logic [DIM_W-1:0]     dim;
    logic [DIM_W-1:0]     row;
    logic [DIM_W-1:0]     col;
    logic [DIM_W-1:0]     k;
    logic [2*DIM_W-1:0]   addr_a;
    logic [2*DIM_W-1:0]   addr_b;
    logic [2*DIM_W-1:0]   addr_c;
    logic                 acc_clear;
    logic                 acc_en;
    logic                 wr_c;
    logic                 busy;
    logic                 done;

    modport master (
        output start, dim,
        input  row, col, k, addr_a, addr_b, addr_c,
        input  acc_clear, acc_en, wr_c, busy, done
    );

    modport slave (
        input  start, dim,
        output row, col, k, addr_a, addr_b, addr_c,
        output acc_clear, acc_en, wr_c, busy, done
    );
endinterface

// File: rtl/mac_sequencer_index_counter.sv
// Modulo-limit up-counter used for the k, col and row loop indices.
// wrap flags the increment that returns the count to zero, so counters
// chain by feeding one stage's wrap into the next stage's inc.
module index_counter #(
    parameter int DIM_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    input  logic [DIM_W-1:0] limit,
    output logic [DIM_W-1:0] count,
    output logic             wrap
);

    assign wrap = inc && (count == limit - DIM_W'(1));

    // Advance on inc, returning to zero after limit-1.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + DIM_W'(1);
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Sequencer for C = A * B on N x N matrices: walks row, col and k,
// emitting A/B/C addresses plus accumulator clear/enable and C write
// strobes. Each C element takes N RUN cycles followed by one WRITE cycle.
module mac_sequencer #(
    parameter int DIM_W = mac_sequencer_pkg::DIM_W
) (
    input logic            clk,
    input logic            clr,
    mac_sequencer_if.slave bus
);
    import mac_sequencer_pkg::*;

    state_t           state;
    state_t           state_next;
    logic [DIM_W-1:0] n_reg;
    logic [DIM_W-1:0] k;
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
    logic             k_inc;
    logic             col_inc;
    logic             k_wrap;
    logic             col_wrap;
    logic             row_wrap;
    logic             acc_clear;
    logic             acc_en;
    logic             wr_c;
    logic             busy;
    logic             done;

    // Indices only move inside RUN/WRITE and always come back to zero at the
    // end of a product, so IDLE always starts from row=col=k=0.
    assign k_inc   = (state == RUN);
    assign col_inc = (state == WRITE);

    index_counter #(.DIM_W(DIM_W)) u_k_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (k_inc),
        .limit (n_reg),
        .count (k),
        .wrap  (k_wrap)
    );

    index_counter #(.DIM_W(DIM_W)) u_col_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (col_inc),
        .limit (n_reg),
        .count (col),
        .wrap  (col_wrap)
    );

    index_counter #(.DIM_W(DIM_W)) u_row_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (col_wrap),
        .limit (n_reg),
        .count (row),
        .wrap  (row_wrap)
    );

    // State register; the matrix size is latched only when a non-empty
    // product is accepted, so later dim changes are invisible to the run.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            n_reg <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.start && bus.dim != '0) begin
                n_reg <= bus.dim;
            end
        end
    end

    // Next-state and strobe decode; strobes depend only on registered
    // state and indices, never on start.
    // NOTE: every output gets a default first so no path leaves a value
    // held, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        wr_c       = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    state_next = (bus.dim == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                acc_en    = 1'b1;
                acc_clear = (k == '0);
                if (k_wrap) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr_c       = 1'b1;
                state_next = row_wrap ? DONE : RUN;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.row       = row;
    assign bus.col       = col;
    assign bus.k         = k;
    assign bus.addr_a    = {row, k};
    assign bus.addr_b    = {k, col};
    assign bus.addr_c    = {row, col};
    assign bus.acc_clear = acc_clear;
    assign bus.acc_en    = acc_en;
    assign bus.wr_c      = wr_c;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: stimulus pushes the expected C-write
// addresses and per-run completion statistics; a negedge monitor pops and
// compares whenever the DUT raises wr_c or done.
module tb_mac_sequencer;

    localparam int W = 4;

    logic clk = 1'b0;
    logic clr;

    mac_sequencer_if #(.DIM_W(W)) bus ();

    mac_sequencer #(.DIM_W(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef enum {EV_WR, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       addr;
        int       busy_n;
        int       en_n;
        int       clr_n;
    } ev_t;

    ev_t sb[$];

    // Matrix size the monitor's index model walks with.
    int cur_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input int a);
        ev_t e;
        e.kind = EV_WR; e.addr = a; e.busy_n = 0; e.en_n = 0; e.clr_n = 0;
        sb.push_back(e);
    endtask

    task automatic expect_done(input int busy_n, input int en_n, input int clr_n);
        ev_t e;
        e.kind = EV_DONE; e.addr = 0; e.busy_n = busy_n; e.en_n = en_n; e.clr_n = clr_n;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_done"},      bus.done,      0);
        check({tag, "_wr_c"},      bus.wr_c,      0);
        check({tag, "_acc_en"},    bus.acc_en,    0);
        check({tag, "_acc_clear"}, bus.acc_clear, 0);
        check({tag, "_idx"},       {bus.row, bus.col, bus.k}, 0);
    endtask

    task automatic do_start(input int n);
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.dim = W'(n);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got=no_done want=done", name);
        end
    endtask

    // Monitor: run statistics, an independent index model for A/B addresses,
    // and scoreboard pops on wr_c / done.
    int busy_cnt = 0, en_cnt = 0, aclr_cnt = 0;
    int mk = 0, mc = 0, mr = 0;

    always @(negedge clk) begin : monitor
        ev_t e;
        if (clr) begin
            busy_cnt = 0; en_cnt = 0; aclr_cnt = 0;
            mk = 0; mc = 0; mr = 0;
        end else begin
            if (bus.busy)      busy_cnt++;
            if (bus.acc_clear) aclr_cnt++;
            if (bus.acc_en) begin
                en_cnt++;
                check("addr_a",    bus.addr_a,    (mr << W) | mk);
                check("addr_b",    bus.addr_b,    (mk << W) | mc);
                check("acc_clear", bus.acc_clear, (mk == 0));
                mk = (mk + 1 == cur_n) ? 0 : mk + 1;
            end
            if (bus.wr_c) begin
                check("acc_en_in_write", bus.acc_en, 0);
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_wr: got addr_c=%0h want=no write", bus.addr_c);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != EV_WR) begin
                        total++; bad++;
                        $display("FAIL event_order: got=wr_c want=done");
                    end else begin
                        check("addr_c", bus.addr_c, e.addr);
                    end
                end
                if (mc + 1 == cur_n) begin
                    mc = 0;
                    mr = (mr + 1 == cur_n) ? 0 : mr + 1;
                end else begin
                    mc = mc + 1;
                end
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got=done want=none");
                end else begin
                    e = sb.pop_front();
                    if (e.kind != EV_DONE) begin
                        total++; bad++;
                        $display("FAIL event_order: got=done want=wr_c addr %0h", e.addr);
                    end else begin
                        check("busy_cycles",  busy_cnt, e.busy_n);
                        check("acc_en_count", en_cnt,   e.en_n);
                        check("acc_clr_count", aclr_cnt, e.clr_n);
                    end
                end
                busy_cnt = 0; en_cnt = 0; aclr_cnt = 0;
                mk = 0; mc = 0; mr = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=still running want=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        clr       = 1'b1;
        bus.start = 1'b0;
        bus.dim   = '0;
        #1 check_all_zero("reset");
        #12 clr = 1'b0;

        // N=2: four C writes in row-major order.
        cur_n = 2;
        expect_wr('h00); expect_wr('h01); expect_wr('h10); expect_wr('h11);
        expect_done(13, 8, 4);
        do_start(2);
        wait_done("n2", 100);

        // N=3.
        cur_n = 3;
        expect_wr('h00); expect_wr('h01); expect_wr('h02);
        expect_wr('h10); expect_wr('h11); expect_wr('h12);
        expect_wr('h20); expect_wr('h21); expect_wr('h22);
        expect_done(37, 27, 9);
        do_start(3);
        wait_done("n3", 200);

        // N=0: straight to DONE, no accumulate or write.
        cur_n = 0;
        expect_done(1, 0, 0);
        do_start(0);
        @(negedge clk);
        check("n0_done_second_cycle", bus.done, 1);
        @(negedge clk);
        check("n0_back_idle", bus.busy, 0);

        // N=1: one RUN, one WRITE, DONE.
        cur_n = 1;
        expect_wr('h00);
        expect_done(3, 1, 1);
        do_start(1);
        @(negedge clk);
        check("n1_run_acc_clear", bus.acc_clear, 1);
        check("n1_run_acc_en",    bus.acc_en,    1);
        check("n1_run_addr_ab",   {bus.addr_a, bus.addr_b}, 0);
        @(negedge clk);
        check("n1_write_wr_c",    bus.wr_c,      1);
        wait_done("n1", 20);

        // N=2 abandoned by an asynchronous clr at busy cycle 5.
        cur_n = 2;
        expect_wr('h00);
        do_start(2);
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2 clr = 1'b1;
        #1 check_all_zero("async_clr");
        @(negedge clk);
        #2 clr = 1'b0;
        repeat (10) @(negedge clk);
        check("after_clr_idle", bus.busy, 0);
        check("after_clr_sb_empty", sb.size(), 0);

        cur_n = 2;
        expect_wr('h00); expect_wr('h01); expect_wr('h10); expect_wr('h11);
        expect_done(13, 8, 4);
        do_start(2);
        wait_done("post_clr_n2", 100);

        // start held high, dim changed mid-run: run stays N=2, and the next
        // run begins only from IDLE with the dim present there.
        cur_n = 2;
        expect_wr('h00); expect_wr('h01); expect_wr('h10); expect_wr('h11);
        expect_done(13, 8, 4);
        expect_wr('h00);
        expect_done(3, 1, 1);
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.dim = W'(2);
        repeat (4) @(posedge clk);
        #1 bus.dim = W'(5);
        wait_done("held_start_n2", 100);
        bus.dim = W'(1);
        cur_n = 1;
        @(negedge clk);
        check("held_start_idle_gap", bus.busy, 0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("held_start_restart", bus.busy, 1);
        wait_done("held_start_n1", 20);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
